de_scoreboard_ctrl: RTL and testbench
=====================================

// Module: de_scoreboard_ctrl
// PURPOSE
//  Decode-side consumer of the AGEX->DE stall/redirect protocol and the WB retire path.
//  Keeps a per-register scoreboard of in-flight writers and detects RAW hazards (stall_de).
//  Holds decode after a control-flow op until AGEX resolves it, then squashes the wrong-path DE slot (flush_de).
//  Sits between the DE latch and the DE->AGEX latch enable.
// PARAMETERS
//  NREGS     32  architectural registers (x0 hardwired zero)
//  REGBITS   5   register index width, log2(NREGS)
//  CNTBITS   2   per-register in-flight writer counter width; CMAX = 2**CNTBITS-1
// PORTS
//  clk              in   1        clock
//  reset            in   1        synchronous, active-high
//  de_valid         in   1        DE holds a valid decoded instruction
//  de_rs1           in   REGBITS  source 1 index
//  de_rs1_used      in   1        instruction reads rs1
//  de_rs2           in   REGBITS  source 2 index
//  de_rs2_used      in   1        instruction reads rs2
//  de_rd            in   REGBITS  destination index
//  de_wr_reg        in   1        instruction writes rd
//  de_is_branch     in   1        BEQ/BNE/BLT/BGE/BLTU/BGEU/JAL/JALR
//  agex_br_resolved in   1        AGEX resolved the outstanding control op this cycle
//  agex_br_taken    in   1        resolution redirects fetch (valid with resolved)
//  wb_valid         in   1        WB retires an instruction this cycle
//  wb_rd            in   REGBITS  retiring destination
//  wb_wr_reg        in   1        retiring instruction writes wb_rd
//  issue            out  1        DE instruction advances into the AGEX latch this cycle
//  stall_de         out  1        hold FE/DE latches
//  flush_de         out  1        squash DE latch contents (wrong path)
//  sb_busy          out  NREGS    bit i = register i has >=1 in-flight writer (registered)
//  sb_err           out  1        sticky: retire with zero count (underflow)
// BEHAVIOUR
//  Reset: all counters 0, state RUN, sb_err 0. Outputs during the reset cycle: issue=0, stall_de=0, flush_de=0.
//  Retire: dec = wb_valid & wb_wr_reg & (wb_rd != 0).
//    The register file is write-before-read, so a reg retiring this cycle with cnt==1 reads as not busy.
//  busy_eff(r) = (cnt[r] - (dec & wb_rd==r)) != 0; busy_eff(0) = 0 always.
//  raw = (rs1_used & busy_eff(rs1)) | (rs2_used & busy_eff(rs2)).
//  waw_ovf = de_wr_reg & de_rd!=0 & cnt[de_rd]==CMAX & !(dec & wb_rd==de_rd).
//  FSM RUN:
//    - issue = de_valid & !raw & !waw_ovf.
//    - stall_de = de_valid & !issue.
//    - issue & de_is_branch -> BR_WAIT next cycle.
//  FSM BR_WAIT:
//    - issue=0, stall_de=1.
//    - On agex_br_resolved: flush_de = agex_br_taken (one cycle), then RUN next cycle.
//    - No issue in the resolve cycle.
//  agex_br_resolved in RUN is ignored; flush_de is 0 in RUN.
//  Counter update (registered):
//    - inc = issue & de_wr_reg & de_rd!=0.
//    - Same reg inc & dec -> unchanged; otherwise +1 / -1.
//    - dec with cnt==0 -> hold 0, set sb_err.
//    - inc never wraps (waw_ovf guarantees it).
//  sb_busy reflects the registered counts (cnt!=0), not busy_eff.
//  Latency: hazard/issue combinational same cycle; scoreboard visible the cycle after issue.
//  Reset mid-BR_WAIT or with counts pending: everything clears next cycle; no flush is emitted.
// TESTING
//  1. Reset -> sb_busy=0, sb_err=0; de_valid=1, rs1=3 -> issue=1 the cycle after reset.
//  2. Issue rd=5; next cycle rs1=5 -> stall_de=1, issue=0; wb_rd=5 retires -> issue=1 that same cycle, sb_busy[5]=0 next cycle.
//  3. Issue BEQ -> 3 cycles stall_de=1; resolved=1, taken=1 -> flush_de=1 for exactly 1 cycle; RUN after.
//  4. Same as 3 with taken=0 -> flush_de=0; issue resumes the cycle after resolve.
//  5. Issue rd=7 while wb retires rd=7 (cnt 1) -> cnt stays 1; three writers to x9 in flight -> 4th stalls (waw_ovf).
//  6. Issue rd=0 -> sb_busy[0] stays 0; wb retire rd=4 with cnt 0 -> sb_err=1 and stays 1 until reset.

Source files
------------

// File: rtl/de_scoreboard_ctrl.sv
// Decode-side hazard control: per-register in-flight writer scoreboard (RAW / WAW-overflow stalls)
// plus a branch-wait FSM that holds decode until AGEX resolves and squashes the wrong-path slot.
module de_scoreboard_ctrl #(
   parameter int NREGS   = 32,
   parameter int REGBITS = 5,
   parameter int CNTBITS = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               de_valid,
   input  logic [REGBITS-1:0] de_rs1,
   input  logic               de_rs1_used,
   input  logic [REGBITS-1:0] de_rs2,
   input  logic               de_rs2_used,
   input  logic [REGBITS-1:0] de_rd,
   input  logic               de_wr_reg,
   input  logic               de_is_branch,
   input  logic               agex_br_resolved,
   input  logic               agex_br_taken,
   input  logic               wb_valid,
   input  logic [REGBITS-1:0] wb_rd,
   input  logic               wb_wr_reg,
   output logic               issue,
   output logic               stall_de,
   output logic               flush_de,
   output logic [NREGS-1:0]   sb_busy,
   output logic               sb_err,
   output logic               dbg_br_wait
);

   // Handshake: issue is the DE->AGEX latch enable; stall_de holds FE/DE whenever a valid
   // instruction (or the branch shadow) cannot issue; flush_de squashes DE for one cycle.

   typedef enum logic {
      ST_RUN     = 1'b0,
      ST_BR_WAIT = 1'b1
   } state_t;

   localparam logic [CNTBITS-1:0] CMAX = '1;
   localparam logic [CNTBITS-1:0] ONE  = CNTBITS'(1);

   state_t             state_q, state_d;
   logic [CNTBITS-1:0] cnt_q [NREGS];
   logic [CNTBITS-1:0] cnt_d [NREGS];
   logic               sb_err_q, sb_err_d;

   logic               dec, inc;
   logic [NREGS-1:0]   dec_hit, inc_hit, busy_eff;
   logic               raw, waw_ovf;

   // Hazard detection; a retiring writer is visible this cycle (write-before-read regfile),
   // so cnt - dec_hit != 0 reduces to cnt != dec_hit.
   always_comb begin
      dec      = wb_valid & wb_wr_reg & (wb_rd != '0);
      dec_hit  = '0;
      busy_eff = '0;
      for (int i = 0; i < NREGS; i++) begin
         dec_hit[i]  = dec & (wb_rd == REGBITS'(i));
         busy_eff[i] = (i != 0) && (cnt_q[i] != {{(CNTBITS-1){1'b0}}, dec_hit[i]});
      end
      raw     = (de_rs1_used & busy_eff[de_rs1]) | (de_rs2_used & busy_eff[de_rs2]);
      waw_ovf = de_wr_reg & (de_rd != '0) & (cnt_q[de_rd] == CMAX) & ~dec_hit[de_rd];
   end

   always_comb begin
      state_d  = state_q;
      issue    = 1'b0;
      stall_de = 1'b0;
      flush_de = 1'b0;
      if (reset) begin
         state_d = ST_RUN;
      end else begin
         case (state_q)
            ST_RUN: begin
               issue    = de_valid & ~raw & ~waw_ovf;
               stall_de = de_valid & ~issue;
               if (issue & de_is_branch) state_d = ST_BR_WAIT;
            end
            ST_BR_WAIT: begin
               stall_de = 1'b1;
               if (agex_br_resolved) begin
                  flush_de = agex_br_taken;
                  state_d  = ST_RUN;
               end
            end
            default: state_d = ST_RUN;
         endcase
      end
   end

   // Counter update; inc and dec on the same register cancel.
   always_comb begin
      inc      = issue & de_wr_reg & (de_rd != '0);
      inc_hit  = '0;
      sb_err_d = sb_err_q;
      for (int i = 0; i < NREGS; i++) begin
         inc_hit[i] = inc & (de_rd == REGBITS'(i));
         cnt_d[i]   = cnt_q[i];
         if (inc_hit[i] && !dec_hit[i]) begin
            cnt_d[i] = cnt_q[i] + ONE;
         end else if (dec_hit[i] && !inc_hit[i]) begin
            if (cnt_q[i] == '0) sb_err_d = 1'b1;
            else                cnt_d[i] = cnt_q[i] - ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_RUN;
         sb_err_q <= 1'b0;
         for (int i = 0; i < NREGS; i++) cnt_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         sb_err_q <= sb_err_d;
         for (int i = 0; i < NREGS; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   always_comb begin
      sb_busy = '0;
      for (int i = 0; i < NREGS; i++) sb_busy[i] = (cnt_q[i] != '0);
   end

   assign sb_err      = sb_err_q;
   assign dbg_br_wait = (state_q == ST_BR_WAIT);

endmodule

// File: tb/tb_de_scoreboard_ctrl.sv
// Scoreboard bench for de_scoreboard_ctrl: a per-register writer-count model predicts each cycle's
// outputs into a queue; a negedge monitor pops and compares against the DUT.
module tb_de_scoreboard_ctrl;

  localparam int W = 37;  // {issue, stall, flush, br_wait, err, busy[31:0]}

  logic        clk = 1'b0;
  logic        reset;
  logic        de_valid, de_rs1_used, de_rs2_used, de_wr_reg, de_is_branch;
  logic [4:0]  de_rs1, de_rs2, de_rd, wb_rd;
  logic        agex_br_resolved, agex_br_taken, wb_valid, wb_wr_reg;
  logic        issue, stall_de, flush_de, sb_err, dbg_br_wait;
  logic [31:0] sb_busy;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];

  // reference model state
  int m_cnt[32];
  bit m_br_wait;
  bit m_err;

  de_scoreboard_ctrl dut (
    .clk(clk), .reset(reset),
    .de_valid(de_valid), .de_rs1(de_rs1), .de_rs1_used(de_rs1_used),
    .de_rs2(de_rs2), .de_rs2_used(de_rs2_used), .de_rd(de_rd),
    .de_wr_reg(de_wr_reg), .de_is_branch(de_is_branch),
    .agex_br_resolved(agex_br_resolved), .agex_br_taken(agex_br_taken),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_wr_reg(wb_wr_reg),
    .issue(issue), .stall_de(stall_de), .flush_de(flush_de),
    .sb_busy(sb_busy), .sb_err(sb_err), .dbg_br_wait(dbg_br_wait)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic idle_inputs();
    reset = 1'b0;
    de_valid = 1'b0; de_rs1 = '0; de_rs1_used = 1'b0; de_rs2 = '0; de_rs2_used = 1'b0;
    de_rd = '0; de_wr_reg = 1'b0; de_is_branch = 1'b0;
    agex_br_resolved = 1'b0; agex_br_taken = 1'b0;
    wb_valid = 1'b0; wb_rd = '0; wb_wr_reg = 1'b0;
  endtask

  // Register r "looks busy" to decode if it still has a writer after this cycle's retirement.
  function automatic bit looks_busy(int r, bit retiring_r);
    if (r == 0) return 1'b0;
    return (m_cnt[r] - (retiring_r ? 1 : 0)) != 0;
  endfunction

  // Predict outputs for the current inputs, push them, advance one clock, update the model.
  task automatic cycle(bit check = 1'b1);
    bit ret, e_issue, e_stall, e_flush, wants_rd, rd_full;
    logic [31:0] e_busy;
    ret = wb_valid && wb_wr_reg && (wb_rd != 0);
    e_issue = 0; e_stall = 0; e_flush = 0;
    for (int r = 0; r < 32; r++) e_busy[r] = (m_cnt[r] != 0);
    if (!reset) begin
      if (m_br_wait) begin
        e_stall = 1;
        e_flush = agex_br_resolved && agex_br_taken;
      end else begin
        wants_rd = de_wr_reg && (de_rd != 0);
        rd_full  = wants_rd && (m_cnt[de_rd] == 3) && !(ret && wb_rd == de_rd);
        e_issue  = de_valid
                   && !(de_rs1_used && looks_busy(de_rs1, ret && wb_rd == de_rs1))
                   && !(de_rs2_used && looks_busy(de_rs2, ret && wb_rd == de_rs2))
                   && !rd_full;
        e_stall  = de_valid && !e_issue;
      end
    end
    if (check) exp_q.push_back({e_issue, e_stall, e_flush, m_br_wait, m_err, e_busy});
    @(posedge clk);
    if (reset) begin
      foreach (m_cnt[r]) m_cnt[r] = 0;
      m_br_wait = 0;
      m_err = 0;
    end else begin
      bit do_inc;
      do_inc = e_issue && de_wr_reg && (de_rd != 0);
      if (do_inc && ret && de_rd == wb_rd) begin
        // writer in and writer out on the same register: net zero
      end else begin
        if (do_inc) m_cnt[de_rd] = m_cnt[de_rd] + 1;
        if (ret) begin
          if (m_cnt[wb_rd] == 0) m_err = 1;
          else m_cnt[wb_rd] = m_cnt[wb_rd] - 1;
        end
      end
      if (m_br_wait) begin
        if (agex_br_resolved) m_br_wait = 0;
      end else if (e_issue && de_is_branch) begin
        m_br_wait = 1;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    cycle(1'b1);
    idle_inputs();
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      chk("issue",    {31'd0, issue},       {31'd0, e[36]});
      chk("stall_de", {31'd0, stall_de},    {31'd0, e[35]});
      chk("flush_de", {31'd0, flush_de},    {31'd0, e[34]});
      chk("br_wait",  {31'd0, dbg_br_wait}, {31'd0, e[33]});
      chk("sb_err",   {31'd0, sb_err},      {31'd0, e[32]});
      chk("sb_busy",  sb_busy,              e[31:0]);
    end
  end

  task automatic issue_wr(int rd);
    idle_inputs();
    de_valid = 1; de_wr_reg = 1; de_rd = 5'(rd);
  endtask

  initial begin
    foreach (m_cnt[r]) m_cnt[r] = 0;
    m_br_wait = 0;
    m_err = 0;

    // first reset cycle: DUT flops still unknown, so nothing is predicted yet
    idle_inputs();
    reset = 1'b1;
    cycle(1'b0);
    do_reset();

    // read of x3 issues immediately after reset
    idle_inputs(); de_valid = 1; de_rs1 = 5'd3; de_rs1_used = 1; cycle();

    // RAW on x5 released by same-cycle retirement
    issue_wr(5); cycle();
    idle_inputs(); de_valid = 1; de_rs1 = 5'd5; de_rs1_used = 1; cycle();
    wb_valid = 1; wb_wr_reg = 1; wb_rd = 5'd5; cycle();
    idle_inputs(); cycle();

    // taken and not-taken branch resolution
    for (int t = 1; t >= 0; t--) begin
      idle_inputs(); de_valid = 1; de_is_branch = 1; cycle();
      idle_inputs(); de_valid = 1;
      repeat (3) cycle();
      agex_br_resolved = 1; agex_br_taken = t[0]; cycle();
      agex_br_resolved = 0; agex_br_taken = 0; cycle();
    end

    // issue x7 while x7 retires; then saturate x9 with three writers
    issue_wr(7); cycle();
    issue_wr(7); wb_valid = 1; wb_wr_reg = 1; wb_rd = 5'd7; cycle();
    repeat (4) begin issue_wr(9); cycle(); end
    // rd=0 never marks busy; retire of idle x4 underflows and sticks
    issue_wr(0); cycle();
    idle_inputs(); wb_valid = 1; wb_wr_reg = 1; wb_rd = 5'd4; cycle();
    idle_inputs(); repeat (2) cycle();
    // reset in the middle of a branch wait with counts pending
    idle_inputs(); de_valid = 1; de_is_branch = 1; de_wr_reg = 1; de_rd = 5'd2; cycle();
    do_reset();
    idle_inputs(); cycle();

    // randomized traffic over a small register window to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      idle_inputs();
      if ($urandom_range(0, 299) == 0) begin
        reset = 1;
      end else begin
        de_valid     = ($urandom_range(0, 3) != 0);
        de_rs1       = 5'($urandom_range(0, 7));
        de_rs1_used  = $urandom_range(0, 1);
        de_rs2       = 5'($urandom_range(0, 7));
        de_rs2_used  = $urandom_range(0, 1);
        de_rd        = 5'($urandom_range(0, 7));
        de_wr_reg    = ($urandom_range(0, 3) != 0);
        de_is_branch = ($urandom_range(0, 7) == 0);
        agex_br_resolved = ($urandom_range(0, 2) == 0);
        agex_br_taken    = $urandom_range(0, 1);
        wb_rd     = 5'($urandom_range(0, 7));
        wb_wr_reg = ($urandom_range(0, 7) != 0);
        wb_valid  = ($urandom_range(0, 1) == 1) && (m_cnt[wb_rd] != 0 || $urandom_range(0, 19) == 0);
        // avoid simultaneous writer-in/writer-out on an idle register
        if (de_wr_reg && de_rd == wb_rd && m_cnt[wb_rd] == 0) wb_valid = 0;
      end
      cycle();
    end

    idle_inputs();
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
